tia_audio_opcode_writer: RTL and testbench

- Opcode-issuing counterpart of the TIA audio circuit.
- Takes CPU-side writes to the six TIA audio registers (AUDC0/1, AUDF0/1, AUDV0/1) and keeps a shadow copy of each channel.
- Packs each channel's settings into a 20-bit opcode and presents it to the audio circuit over a valid/ready handshake.
- Repeated writes to the same channel coalesce; issues alternate between channels (round-robin) and are spaced by a programmable gap.

---
 rtl/tia_audio_pkg.sv | 55 +++++
 rtl/tia_audio_opcode_writer.sv | 139 +++++++++++++
 tb/tb_tia_audio_opcode_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tia_audio_pkg.sv
// Shared definitions for the TIA audio opcode writer: register addresses,
// opcode field layout, FSM states and the opcode pack helper.
package tia_audio_pkg;

    localparam int OPCODE_W = 20;

    localparam logic [5:0] ADDR_AUDC0 = 6'h15;
    localparam logic [5:0] ADDR_AUDC1 = 6'h16;
    localparam logic [5:0] ADDR_AUDF0 = 6'h17;
    localparam logic [5:0] ADDR_AUDF1 = 6'h18;
    localparam logic [5:0] ADDR_AUDV0 = 6'h19;
    localparam logic [5:0] ADDR_AUDV1 = 6'h1A;

    localparam int OP_CH_BIT   = 19;
    localparam int OP_AUDC_MSB = 18;
    localparam int OP_AUDC_LSB = 15;
    localparam int OP_AUDF_MSB = 14;
    localparam int OP_AUDF_LSB = 10;
    localparam int OP_AUDV_MSB = 9;
    localparam int OP_AUDV_LSB = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FLD_AUDC = 2'd0,
        FLD_AUDF = 2'd1,
        FLD_AUDV = 2'd2
    } field_t;

    typedef struct packed {
        logic [3:0] audc;
        logic [4:0] audf;
        logic [3:0] audv;
    } chan_regs_t;

    function automatic logic [OPCODE_W-1:0] pack_opcode(
        input logic       ch,
        input logic [3:0] audc,
        input logic [4:0] audf,
        input logic [3:0] audv
    );
        logic [OPCODE_W-1:0] op;
        op                          = '0;
        op[OP_CH_BIT]               = ch;
        op[OP_AUDC_MSB:OP_AUDC_LSB] = audc;
        op[OP_AUDF_MSB:OP_AUDF_LSB] = audf;
        op[OP_AUDV_MSB:OP_AUDV_LSB] = audv;
        return op;
    endfunction

endpackage

// File: rtl/tia_audio_opcode_writer.sv
// Shadows CPU writes to the TIA audio registers and issues per-channel opcodes round-robin.
// Latency: write sampled at edge N -> opcode_valid high after edge N+1 (FSM idle).
// Backpressure: opcode/opcode_valid held until opcode_ready; writes keep coalescing meanwhile.
module tia_audio_opcode_writer
    import tia_audio_pkg::*;
#(
    parameter int MIN_GAP = 4,
    parameter int GAP_W   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [5:0]          wr_addr,
    input  logic [7:0]          wr_data,
    output logic [OPCODE_W-1:0] opcode,
    output logic                opcode_valid,
    input  logic                opcode_ready,
    output logic [1:0]          ch_pending
);

    localparam bit               HAS_GAP  = (MIN_GAP != 0);
    localparam logic [GAP_W-1:0] GAP_LOAD = HAS_GAP ? GAP_W'(MIN_GAP - 1) : '0;

    state_t              state_q, state_d;
    chan_regs_t          shadow_q [2];
    logic [1:0]          dirty_q, dirty_d;
    logic                last_ch_q;
    logic [OPCODE_W-1:0] opcode_q;
    logic [GAP_W-1:0]    gap_cnt_q;

    logic   wr_hit;
    logic   wr_ch;
    field_t wr_field;
    logic   sel_ch;
    logic   load;
    logic   accept;
    logic   unused_wr_bits;

    assign unused_wr_bits = &{1'b0, wr_data[7:5]};

    always_comb begin
        wr_hit   = 1'b0;
        wr_ch    = 1'b0;
        wr_field = FLD_AUDC;
        if (wr_en) begin
            case (wr_addr)
                ADDR_AUDC0: begin wr_hit = 1'b1; wr_ch = 1'b0; wr_field = FLD_AUDC; end
                ADDR_AUDC1: begin wr_hit = 1'b1; wr_ch = 1'b1; wr_field = FLD_AUDC; end
                ADDR_AUDF0: begin wr_hit = 1'b1; wr_ch = 1'b0; wr_field = FLD_AUDF; end
                ADDR_AUDF1: begin wr_hit = 1'b1; wr_ch = 1'b1; wr_field = FLD_AUDF; end
                ADDR_AUDV0: begin wr_hit = 1'b1; wr_ch = 1'b0; wr_field = FLD_AUDV; end
                ADDR_AUDV1: begin wr_hit = 1'b1; wr_ch = 1'b1; wr_field = FLD_AUDV; end
                default:    wr_hit = 1'b0;
            endcase
        end
    end

    // Tie between both channels goes to the one not issued last.
    assign sel_ch = (dirty_q == 2'b11) ? ~last_ch_q : dirty_q[1];
    assign load   = (state_q == IDLE) && (|dirty_q);
    assign accept = (state_q == ISSUE) && opcode_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|dirty_q) state_d = ISSUE;
            ISSUE:   if (opcode_ready) state_d = HAS_GAP ? GAP : IDLE;
            GAP:     if (gap_cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        opcode_valid = (state_q == ISSUE);
    end

    assign opcode     = opcode_q;
    assign ch_pending = dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (wr_hit) begin
            case (wr_field)
                FLD_AUDC: shadow_q[wr_ch].audc <= wr_data[3:0];
                FLD_AUDF: shadow_q[wr_ch].audf <= wr_data[4:0];
                FLD_AUDV: shadow_q[wr_ch].audv <= wr_data[3:0];
                default:  ;
            endcase
        end
    end

    // A write landing on the same edge as the load re-marks the channel dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (load) begin
            dirty_d[sel_ch] = 1'b0;
        end
        if (wr_hit) begin
            dirty_d[wr_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q   <= '0;
            last_ch_q <= 1'b1;
            opcode_q  <= '0;
        end else begin
            dirty_q <= dirty_d;
            if (load) begin
                last_ch_q <= sel_ch;
                opcode_q  <= pack_opcode(sel_ch, shadow_q[sel_ch].audc,
                                         shadow_q[sel_ch].audf, shadow_q[sel_ch].audv);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else if (accept && HAS_GAP) begin
            gap_cnt_q <= GAP_LOAD;
        end else if ((state_q == GAP) && (gap_cnt_q != '0)) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
        end
    end

endmodule

// File: tb/tb_tia_audio_opcode_writer.sv
// Directed bench for tia_audio_opcode_writer with immediate-assertion checks.
module tb_tia_audio_opcode_writer;

    localparam int MIN_GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [19:0] opcode;
    logic        opcode_valid;
    logic        opcode_ready;
    logic [1:0]  ch_pending;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tia_audio_opcode_writer #(.MIN_GAP(MIN_GAP), .GAP_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .opcode       (opcode),
        .opcode_valid (opcode_valid),
        .opcode_ready (opcode_ready),
        .ch_pending   (ch_pending)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
    endtask

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!opcode_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_timeout"}, 20'(opcode_valid), 20'd1);
    endtask

    task automatic settle();
        for (int i = 0; i < 8; i++) step();
    endtask

    initial begin
        int  n;
        logic ok;

        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        opcode_ready = 1'b0;
        #2;
        chk("rst_valid", 20'(opcode_valid), 20'd0);
        chk("rst_opcode", opcode, 20'h00000);
        chk("rst_pending", 20'(ch_pending), 20'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_rst", 20'(opcode_valid), 20'd0);

        // Coalescing writes to channel 0
        opcode_ready = 1'b1;
        wr(6'h15, 8'h04);
        chk("t1_lat_n", 20'(opcode_valid), 20'd0);
        chk("t1_pend_n", 20'(ch_pending), 20'd1);
        wr(6'h17, 8'h1F);
        chk("t1_valid", 20'(opcode_valid), 20'd1);
        chk("t1_op0", opcode, 20'h20000);
        wr(6'h19, 8'h0F);
        chk("t1_accepted", 20'(opcode_valid), 20'd0);
        wait_valid("t1_second", n);
        chk("t1_gap", 20'(n >= MIN_GAP && n <= MIN_GAP + 1), 20'd1);
        chk("t1_op1", opcode, 20'h27FC0);
        chk("t1_pend_end", 20'(ch_pending), 20'd0);
        step();
        settle();

        // Backpressure hold and snapshot semantics on channel 1
        opcode_ready = 1'b0;
        wr(6'h16, 8'h08);
        step();
        chk("t2_op", opcode, 20'hC0000);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (opcode !== 20'hC0000 || opcode_valid !== 1'b1) ok = 1'b0;
        end
        chk("t2_hold", 20'(ok), 20'd1);
        wr(6'h16, 8'h03);
        chk("t2_snapshot", opcode, 20'hC0000);
        chk("t2_pend", 20'(ch_pending), 20'd2);
        opcode_ready = 1'b1;
        step();
        chk("t2_accepted", 20'(opcode_valid), 20'd0);
        wait_valid("t2_reissue", n);
        chk("t2_gap", 20'(n >= MIN_GAP && n <= MIN_GAP + 1), 20'd1);
        chk("t2_op_new", opcode, 20'h98000);
        step();
        settle();

        // Round-robin between channels
        wr(6'h15, 8'h05);
        wr(6'h16, 8'h06);
        chk("t3_ch0", opcode, 20'h2FFC0);
        step();
        wait_valid("t3_ch1", n);
        chk("t3_gap", 20'(n >= MIN_GAP && n <= MIN_GAP + 1), 20'd1);
        chk("t3_ch1_op", opcode, 20'hB0000);
        step();
        settle();
        opcode_ready = 1'b0;
        wr(6'h19, 8'h01);
        step();
        chk("t3_dual_first", opcode, 20'h2FC40);
        wr(6'h18, 8'h0A);
        wr(6'h17, 8'h00);
        chk("t3_dual_pend", 20'(ch_pending), 20'd3);
        opcode_ready = 1'b1;
        step();
        wait_valid("t3_rr1", n);
        chk("t3_rr1_op", opcode, 20'hB2800);
        step();
        wait_valid("t3_rr0", n);
        chk("t3_rr0_op", opcode, 20'h28040);
        chk("t3_pend_end", 20'(ch_pending), 20'd0);
        step();
        settle();

        // Unmapped addresses have no effect
        wr(6'h3F, 8'hFF);
        wr(6'h14, 8'hFF);
        wr(6'h1B, 8'hFF);
        step();
        step();
        chk("t4_valid", 20'(opcode_valid), 20'd0);
        chk("t4_pend", 20'(ch_pending), 20'd0);

        // Asynchronous reset mid-handshake; also proves ch1 shadow survived t4
        opcode_ready = 1'b0;
        wr(6'h1A, 8'h07);
        step();
        chk("t5_op", opcode, 20'hB29C0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 20'(opcode_valid), 20'd0);
        chk("t5_rst_opcode", opcode, 20'h00000);
        chk("t5_rst_pend", 20'(ch_pending), 20'd0);
        #3;
        rst_n = 1'b1;
        opcode_ready = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (opcode_valid !== 1'b0) ok = 1'b0;
        end
        chk("t5_no_reissue", 20'(ok), 20'd1);

        // Write landing on the same edge as the IDLE load of that channel
        wr(6'h15, 8'h09);
        wr(6'h17, 8'h03);
        chk("t6_old", opcode, 20'h48000);
        chk("t6_pend", 20'(ch_pending), 20'd1);
        step();
        wait_valid("t6_new", n);
        chk("t6_new_op", opcode, 20'h48C00);
        chk("t6_pend_end", 20'(ch_pending), 20'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
